// File: rtl/seven_seg_pkg.sv
// Shared types and the hex-to-segment table for the seven-segment scanner.
// Segment patterns are active-high and ordered {a,b,c,d,e,f,g}.
package seven_seg_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_OFF = 7'b000_0000;

    function automatic seg7_t hex_to_seg(input logic [3:0] nibble);
        seg7_t pattern;
        case (nibble)
            4'h0:    pattern = 7'b111_1110;
            4'h1:    pattern = 7'b011_0000;
            4'h2:    pattern = 7'b110_1101;
            4'h3:    pattern = 7'b111_1001;
            4'h4:    pattern = 7'b011_0011;
            4'h5:    pattern = 7'b101_1011;
            4'h6:    pattern = 7'b101_1111;
            4'h7:    pattern = 7'b111_0000;
            4'h8:    pattern = 7'b111_1111;
            4'h9:    pattern = 7'b111_1011;
            4'hA:    pattern = 7'b111_0111;
            4'hB:    pattern = 7'b001_1111;
            4'hC:    pattern = 7'b100_1110;
            4'hD:    pattern = 7'b011_1101;
            4'hE:    pattern = 7'b100_1111;
            4'hF:    pattern = 7'b100_0111;
            default: pattern = SEG_OFF;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seven_seg_scan_timer.sv
// Slot timing for the scanner: prescaler, digit index, frame boundary,
// registered frame_start pulse and the PWM on/off compare.
module seven_seg_scan_timer
    import seven_seg_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int PRESCALE_W = 16,
    parameter int BRIGHT_W   = 4,
    parameter int IDX_W      = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [BRIGHT_W-1:0] brightness,
    output logic [IDX_W-1:0]    digit_idx,
    output logic                frame_boundary,
    output logic                frame_start,
    output logic                pwm_on
);

    logic [PRESCALE_W-1:0] prescaler_r;
    logic [IDX_W-1:0]      idx_r;
    logic                  frame_start_r;
    logic                  slot_end_s;
    logic                  last_digit_s;

    assign slot_end_s     = &prescaler_r;
    assign last_digit_s   = (idx_r == IDX_W'(DIGITS - 1));
    assign frame_boundary = slot_end_s && last_digit_s;
    // Top bits of the prescaler form the PWM ramp within each slot.
    assign pwm_on         = (prescaler_r[PRESCALE_W-1 -: BRIGHT_W] < brightness);
    assign digit_idx      = idx_r;
    assign frame_start    = frame_start_r;

    // Prescaler, digit index and frame_start pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prescaler_r   <= '0;
            idx_r         <= '0;
            frame_start_r <= 1'b0;
        end else begin
            prescaler_r   <= prescaler_r + PRESCALE_W'(1);
            frame_start_r <= frame_boundary;
            if (slot_end_s) begin
                if (last_digit_s) begin
                    idx_r <= '0;
                end else begin
                    idx_r <= idx_r + IDX_W'(1);
                end
            end else begin
                idx_r <= idx_r;
            end
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed N-digit seven-segment driver with double-buffered data,
// leading-zero blanking, PWM brightness and configurable pin polarity.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int PRESCALE_W     = 16,
    parameter int BRIGHT_W       = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [4*DIGITS-1:0]   number,
    input  logic [DIGITS-1:0]     digit_enables,
    input  logic [DIGITS-1:0]     dots,
    input  logic                  lz_suppress,
    input  logic [BRIGHT_W-1:0]   brightness,
    input  logic                  load,
    output logic [7:0]            segments,
    output logic [DIGITS-1:0]     digit_drive,
    output logic                  frame_start
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [7:0]        SEG_IDLE = {8{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] DIG_IDLE = {DIGITS{DIG_ACTIVE_LOW}};

    logic [IDX_W-1:0]    digit_idx_s;
    logic                frame_boundary_s;
    logic                pwm_on_s;

    logic [4*DIGITS-1:0] pend_number_r, act_number_r;
    logic [DIGITS-1:0]   pend_en_r, act_en_r;
    logic [DIGITS-1:0]   pend_dots_r, act_dots_r;
    logic                pend_lz_r, act_lz_r;
    logic                pend_valid_r;

    logic [3:0]          nibble_s;
    logic                blank_s;
    logic                lit_s;
    seg7_t               pattern_s;
    logic [7:0]          seg_next_s;
    logic [DIGITS-1:0]   dig_next_s;
    logic [7:0]          segments_r;
    logic [DIGITS-1:0]   digit_drive_r;

    seven_seg_scan_timer #(
        .DIGITS     (DIGITS),
        .PRESCALE_W (PRESCALE_W),
        .BRIGHT_W   (BRIGHT_W),
        .IDX_W      (IDX_W)
    ) u_timer (
        .clock          (clock),
        .reset_n        (reset_n),
        .brightness     (brightness),
        .digit_idx      (digit_idx_s),
        .frame_boundary (frame_boundary_s),
        .frame_start    (frame_start),
        .pwm_on         (pwm_on_s)
    );

    // Pending/active display buffers; a load on a boundary waits for the next one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_number_r <= '0;
            pend_en_r     <= '0;
            pend_dots_r   <= '0;
            pend_lz_r     <= 1'b0;
            pend_valid_r  <= 1'b0;
            act_number_r  <= '0;
            act_en_r      <= '0;
            act_dots_r    <= '0;
            act_lz_r      <= 1'b0;
        end else begin
            if (frame_boundary_s && pend_valid_r) begin
                act_number_r <= pend_number_r;
                act_en_r     <= pend_en_r;
                act_dots_r   <= pend_dots_r;
                act_lz_r     <= pend_lz_r;
            end
            if (load) begin
                pend_number_r <= number;
                pend_en_r     <= digit_enables;
                pend_dots_r   <= dots;
                pend_lz_r     <= lz_suppress;
                pend_valid_r  <= 1'b1;
            end else if (frame_boundary_s) begin
                pend_valid_r  <= 1'b0;
            end else begin
                pend_valid_r  <= pend_valid_r;
            end
        end
    end

    // Decode, leading-zero blanking and ghosting guard for the current slot.
    always_comb begin
        nibble_s = act_number_r[{digit_idx_s, 2'b00} +: 4];
        blank_s  = act_lz_r && (digit_idx_s != '0);
        for (int i = 0; i < DIGITS; i++) begin
            blank_s = blank_s &&
                      !((i >= int'(digit_idx_s)) && (act_number_r[i*4 +: 4] != 4'h0));
        end
        pattern_s  = blank_s ? SEG_OFF : hex_to_seg(nibble_s);
        lit_s      = act_en_r[digit_idx_s] && pwm_on_s;
        seg_next_s = lit_s ? {pattern_s, act_dots_r[digit_idx_s]} : 8'h00;
        dig_next_s = lit_s ? (DIGITS'(1'b1) << digit_idx_s) : '0;
    end

    // Output registers; pin polarity is applied only here.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            segments_r    <= SEG_IDLE;
            digit_drive_r <= DIG_IDLE;
        end else begin
            segments_r    <= seg_next_s ^ SEG_IDLE;
            digit_drive_r <= dig_next_s ^ DIG_IDLE;
        end
    end

    assign segments    = segments_r;
    assign digit_drive = digit_drive_r;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomised self-checking bench: a cycle-count based reference model for a
// 4-digit scanner plus directed checks on a 3-digit instance.
module tb_seven_seg_scanner;

    logic        clock;
    logic        reset_n;
    logic [15:0] number;
    logic [3:0]  digit_enables, dots;
    logic        lz_suppress, load;
    logic [1:0]  brightness;
    logic [7:0]  segments;
    logic [3:0]  digit_drive;
    logic        frame_start;

    logic [11:0] number_b;
    logic [2:0]  en_b, dots_b;
    logic        load_b;
    logic [7:0]  seg_b;
    logic [2:0]  dig_b;
    logic        fs_b;

    int vectors = 0;
    int miscompares = 0;

    logic [6:0] seg_tbl [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    seven_seg_scanner #(.DIGITS(4), .PRESCALE_W(4), .BRIGHT_W(2),
                        .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b1)) dut (
        .clock(clock), .reset_n(reset_n), .number(number), .digit_enables(digit_enables),
        .dots(dots), .lz_suppress(lz_suppress), .brightness(brightness), .load(load),
        .segments(segments), .digit_drive(digit_drive), .frame_start(frame_start));

    seven_seg_scanner #(.DIGITS(3), .PRESCALE_W(4), .BRIGHT_W(2),
                        .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b1)) dut_b (
        .clock(clock), .reset_n(reset_n), .number(number_b), .digit_enables(en_b),
        .dots(dots_b), .lz_suppress(1'b0), .brightness(brightness), .load(load_b),
        .segments(seg_b), .digit_drive(dig_b), .frame_start(fs_b));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: c clocks after reset, slot = c/16 mod 4, phase = c mod 16.
    int          cyc;
    logic [15:0] m_pnum, m_anum;
    logic [3:0]  m_pen, m_aen, m_pdots, m_adots;
    logic        m_plz, m_alz, m_pval;
    logic [7:0]  exp_seg;
    logic [3:0]  exp_dig;
    logic        exp_fs;

    function automatic logic model_lit(int c, logic [3:0] en, logic [1:0] br);
        int slot = (c / 16) % 4;
        int phase = c % 16;
        return en[slot] && ((phase / 4) < int'(br));
    endfunction

    function automatic logic [7:0] model_seg(int c, logic [15:0] num, logic [3:0] en,
                                             logic [3:0] dp, logic lz, logic [1:0] br);
        int slot = (c / 16) % 4;
        logic [3:0] nib = num[slot*4 +: 4];
        logic blank = lz && (slot != 0) && ((num >> (slot*4)) == 16'h0);
        if (!model_lit(c, en, br)) return 8'h00;
        return {blank ? 7'h00 : seg_tbl[nib], dp[slot]};
    endfunction

    function automatic logic [3:0] model_dig(int c, logic [3:0] en, logic [1:0] br);
        int slot = (c / 16) % 4;
        if (!model_lit(c, en, br)) return 4'hF;
        return ~(4'b0001 << slot);
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cyc <= 0;
            m_pnum <= 16'h0; m_pen <= 4'h0; m_pdots <= 4'h0; m_plz <= 1'b0; m_pval <= 1'b0;
            m_anum <= 16'h0; m_aen <= 4'h0; m_adots <= 4'h0; m_alz <= 1'b0;
            exp_seg <= 8'h00; exp_dig <= 4'hF; exp_fs <= 1'b0;
        end else begin
            exp_seg <= model_seg(cyc, m_anum, m_aen, m_adots, m_alz, brightness);
            exp_dig <= model_dig(cyc, m_aen, brightness);
            exp_fs  <= ((cyc % 64) == 63);
            if (((cyc % 64) == 63) && m_pval) begin
                m_anum <= m_pnum; m_aen <= m_pen; m_adots <= m_pdots; m_alz <= m_plz;
            end
            if (load) begin
                m_pnum <= number; m_pen <= digit_enables; m_pdots <= dots;
                m_plz <= lz_suppress; m_pval <= 1'b1;
            end else if ((cyc % 64) == 63) begin
                m_pval <= 1'b0;
            end
            cyc <= cyc + 1;
        end
    end

    task automatic test_reset();
        reset_n = 1'b0; number = 16'h0; digit_enables = 4'hF; dots = 4'h0;
        lz_suppress = 1'b0; brightness = 2'd3; load = 1'b0;
        number_b = 12'h0; en_b = 3'h0; dots_b = 3'h0; load_b = 1'b0;
        repeat (3) @(negedge clock);
        vectors++;
        if (segments !== 8'h00 || digit_drive !== 4'hF || frame_start !== 1'b0 ||
            seg_b !== 8'h00 || dig_b !== 3'b111 || fs_b !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_values seg=%b dig=%b fs=%b segb=%b digb=%b fsb=%b want 0/1111/0/0/111/0",
                     segments, digit_drive, frame_start, seg_b, dig_b, fs_b);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_basic_scan();
        logic seen = 1'b0;
        int lit_cnt [4] = '{0, 0, 0, 0};
        number = 16'h12AF; digit_enables = 4'hF; dots = 4'h0; lz_suppress = 1'b0; load = 1'b1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clock); vectors++;
            if ({segments, digit_drive, frame_start} !== {exp_seg, exp_dig, exp_fs}) begin
                miscompares++;
                $display("FAIL basic_align seg=%b dig=%b fs=%b want %b %b %b",
                         segments, digit_drive, frame_start, exp_seg, exp_dig, exp_fs);
            end
            load = 1'b0;
            seen = frame_start;
        end
        vectors++;
        if (!seen) begin miscompares++; $display("FAIL basic_timeout no frame_start"); end
        for (int i = 1; i <= 64; i++) begin
            @(negedge clock); vectors++;
            if ({segments, digit_drive, frame_start} !== {exp_seg, exp_dig, exp_fs}) begin
                miscompares++;
                $display("FAIL basic_scan i=%0d seg=%b dig=%b fs=%b want %b %b %b",
                         i, segments, digit_drive, frame_start, exp_seg, exp_dig, exp_fs);
            end
            if (digit_drive !== 4'hF) lit_cnt[(i-1)/16]++;
            if (i == 1 && (segments !== 8'b10001110 || digit_drive !== 4'b1110)) begin
                miscompares++;
                $display("FAIL basic_slot0 seg=%b dig=%b want 10001110 1110", segments, digit_drive);
            end
            if (i == 49 && (segments !== 8'b01100000 || digit_drive !== 4'b0111)) begin
                miscompares++;
                $display("FAIL basic_slot3 seg=%b dig=%b want 01100000 0111", segments, digit_drive);
            end
        end
        for (int s = 0; s < 4; s++) begin
            vectors++;
            if (lit_cnt[s] != 12) begin
                miscompares++;
                $display("FAIL basic_duty slot=%0d lit=%0d want 12", s, lit_cnt[s]);
            end
        end
    endtask

    task automatic test_double_buffer();
        // Entered right after a frame_start was seen, so i counts from slot 0, phase 0.
        for (int i = 1; i <= 80; i++) begin
            @(negedge clock); vectors++;
            if ({segments, digit_drive, frame_start} !== {exp_seg, exp_dig, exp_fs}) begin
                miscompares++;
                $display("FAIL dbuf i=%0d seg=%b dig=%b fs=%b want %b %b %b",
                         i, segments, digit_drive, frame_start, exp_seg, exp_dig, exp_fs);
            end
            if (i == 49 && segments !== 8'b01100000) begin
                miscompares++;
                $display("FAIL dbuf_old_kept seg=%b want 01100000", segments);
            end
            if ((i == 65 || i == 81) && segments !== 8'b11011010) begin
                miscompares++;
                $display("FAIL dbuf_last_wins i=%0d seg=%b want 11011010", i, segments);
            end
            load = 1'b0;
            if (i == 20) begin number = 16'h1111; load = 1'b1; end
            if (i == 40) begin number = 16'h2222; load = 1'b1; end
        end
    endtask

    task automatic test_leading_zeros();
        // Entered at frame offset 16 (i=80 of the previous task): align to i=17.
        for (int i = 17; i <= 170; i++) begin
            @(negedge clock); vectors++;
            if ({segments, digit_drive, frame_start} !== {exp_seg, exp_dig, exp_fs}) begin
                miscompares++;
                $display("FAIL lz i=%0d seg=%b dig=%b fs=%b want %b %b %b",
                         i, segments, digit_drive, frame_start, exp_seg, exp_dig, exp_fs);
            end
            if ((i == 65 || i == 129) && segments !== 8'b11111100) begin
                miscompares++;
                $display("FAIL lz_digit0 i=%0d seg=%b want 11111100", i, segments);
            end
            if (i == 81 && segments !== 8'b10110110) begin
                miscompares++;
                $display("FAIL lz_digit1 seg=%b want 10110110", segments);
            end
            if ((i == 97 || i == 113 || i == 145) && segments !== 8'h00) begin
                miscompares++;
                $display("FAIL lz_blank i=%0d seg=%b want 00000000", i, segments);
            end
            if (i == 161 && (segments !== 8'b00000001 || digit_drive !== 4'b1011)) begin
                miscompares++;
                $display("FAIL lz_blank_dp seg=%b dig=%b want 00000001 1011", segments, digit_drive);
            end
            load = 1'b0;
            if (i == 17) begin number = 16'h0050; lz_suppress = 1'b1; dots = 4'h0; load = 1'b1; end
            if (i == 100) begin number = 16'h0000; dots = 4'b0100; load = 1'b1; end
        end
    endtask

    task automatic test_brightness_enables();
        int lit_cnt [4] = '{0, 0, 0, 0};
        // Entered at frame offset 42; i keeps the frame-relative numbering.
        for (int i = 43; i <= 192; i++) begin
            @(negedge clock); vectors++;
            if ({segments, digit_drive, frame_start} !== {exp_seg, exp_dig, exp_fs}) begin
                miscompares++;
                $display("FAIL bright i=%0d seg=%b dig=%b fs=%b want %b %b %b",
                         i, segments, digit_drive, frame_start, exp_seg, exp_dig, exp_fs);
            end
            if (i >= 44 && i <= 64 && (digit_drive !== 4'hF || segments !== 8'h00)) begin
                miscompares++;
                $display("FAIL bright_zero i=%0d seg=%b dig=%b want 00000000 1111", i, segments, digit_drive);
            end
            if (i >= 129) begin
                if (digit_drive !== 4'hF) lit_cnt[(i-129)/16]++;
                if (digit_drive[1] !== 1'b1 || digit_drive[3] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL enable_mask i=%0d dig=%b want bits 1,3 high", i, digit_drive);
                end
            end
            load = 1'b0;
            if (i == 43) brightness = 2'd0;
            if (i == 64) begin
                brightness = 2'd1; number = 16'h12AF; digit_enables = 4'b0101;
                dots = 4'h0; lz_suppress = 1'b0; load = 1'b1;
            end
        end
        for (int s = 0; s < 4; s++) begin
            vectors++;
            if (lit_cnt[s] != ((s % 2 == 0) ? 4 : 0)) begin
                miscompares++;
                $display("FAIL bright_duty slot=%0d lit=%0d want %0d", s, lit_cnt[s], (s % 2 == 0) ? 4 : 0);
            end
        end
        brightness = 2'd3;
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            @(negedge clock); vectors++;
            if ({segments, digit_drive, frame_start} !== {exp_seg, exp_dig, exp_fs}) begin
                miscompares++;
                $display("FAIL random i=%0d seg=%b dig=%b fs=%b want %b %b %b",
                         i, segments, digit_drive, frame_start, exp_seg, exp_dig, exp_fs);
            end
            load = 1'b0;
            if ($urandom_range(15) == 0) begin
                number = 16'($urandom);
                if ($urandom_range(2) == 0) number = number & 16'h00FF;
                digit_enables = 4'($urandom); dots = 4'($urandom);
                lz_suppress = 1'($urandom); load = 1'b1;
            end
            if ($urandom_range(39) == 0) brightness = 2'($urandom);
        end
        brightness = 2'd3;
    endtask

    task automatic test_reset_mid_frame();
        logic seen = 1'b0;
        number = 16'h8888; digit_enables = 4'hF; dots = 4'hF; lz_suppress = 1'b0; load = 1'b1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clock); vectors++;
            if ({segments, digit_drive, frame_start} !== {exp_seg, exp_dig, exp_fs}) begin
                miscompares++;
                $display("FAIL rstmid_align seg=%b dig=%b fs=%b want %b %b %b",
                         segments, digit_drive, frame_start, exp_seg, exp_dig, exp_fs);
            end
            load = 1'b0;
            seen = frame_start;
        end
        vectors++;
        if (!seen) begin miscompares++; $display("FAIL rstmid_timeout no frame_start"); end
        // Slot 2 of a lit frame, then queue pending data that the reset must discard.
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            load = (i == 35);
            if (i == 35) number = 16'h4321;
        end
        load = 1'b0;
        #2 reset_n = 1'b0;
        #1 vectors++;
        if (segments !== 8'h00 || digit_drive !== 4'hF || frame_start !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_async seg=%b dig=%b fs=%b want 00000000 1111 0",
                     segments, digit_drive, frame_start);
        end
        repeat (10) begin
            @(negedge clock); vectors++;
            if (segments !== 8'h00 || digit_drive !== 4'hF || frame_start !== 1'b0) begin
                miscompares++;
                $display("FAIL rstmid_hold seg=%b dig=%b fs=%b want 00000000 1111 0",
                         segments, digit_drive, frame_start);
            end
        end
        reset_n = 1'b1;
        for (int i = 1; i <= 130; i++) begin
            @(negedge clock); vectors++;
            if ({segments, digit_drive, frame_start} !== {exp_seg, exp_dig, exp_fs} ||
                digit_drive !== 4'hF || frame_start !== (i % 64 == 0)) begin
                miscompares++;
                $display("FAIL rstmid_restart i=%0d seg=%b dig=%b fs=%b want %b 1111 %b",
                         i, segments, digit_drive, frame_start, exp_seg, (i % 64 == 0));
            end
        end
    endtask

    task automatic test_digits3();
        logic seen = 1'b0;
        @(negedge clock) reset_n = 1'b0;
        @(negedge clock) reset_n = 1'b1;
        number_b = 12'h321; en_b = 3'b111; dots_b = 3'b010; load_b = 1'b1; brightness = 2'd3;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clock);
            load_b = 1'b0;
            seen = fs_b;
        end
        vectors++;
        if (!seen) begin miscompares++; $display("FAIL d3_timeout no frame_start"); end
        for (int j = 1; j <= 96; j++) begin
            int slot = ((j - 1) / 16) % 3;
            int phase = (j - 1) % 16;
            logic [3:0] nib = number_b[slot*4 +: 4];
            logic lit = (phase / 4) < 3;
            logic [7:0] want_seg = lit ? {seg_tbl[nib], dots_b[slot]} : 8'h00;
            logic [2:0] want_dig = lit ? ~(3'b001 << slot) : 3'b111;
            @(negedge clock); vectors++;
            if (seg_b !== want_seg || dig_b !== want_dig || fs_b !== (j % 48 == 0)) begin
                miscompares++;
                $display("FAIL d3_scan j=%0d seg=%b dig=%b fs=%b want %b %b %b",
                         j, seg_b, dig_b, fs_b, want_seg, want_dig, (j % 48 == 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_double_buffer();
        test_leading_zeros();
        test_brightness_enables();
        test_random();
        test_reset_mid_frame();
        test_digits3();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
Parametrised time-multiplexed seven-segment display driver for N hex digits with per-digit decimal points, leading-zero suppression, PWM brightness control and selectable output polarity. Display data is double-buffered, so updates from the CPU-side register interface take effect only at frame boundaries and never tear. The block sits between the peripheral register bank and the board's segment/anode pins.

Parameters:
DIGITS, 4, number of multiplexed digits (1..8)
PRESCALE_W, 16, prescaler width; each digit slot lasts 2**PRESCALE_W clocks
BRIGHT_W, 4, brightness resolution in bits (BRIGHT_W <= PRESCALE_W)
SEG_ACTIVE_LOW, 0, 1 = segment outputs driven low when lit
DIG_ACTIVE_LOW, 1, 1 = digit select outputs driven low when selected

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
number  in  4*DIGITS  hex nibbles; digit 0 = bits [3:0]
digit_enables  in  DIGITS  per-digit enable
dots  in  DIGITS  per-digit decimal point
lz_suppress  in  1  blank leading zero digits
brightness  in  BRIGHT_W  duty level; 0 = dark
load  in  1  one-cycle strobe: capture number/digit_enables/dots/lz_suppress into the pending buffer
segments  out  8  {a,b,c,d,e,f,g,dp}, registered
digit_drive  out  DIGITS  digit select, one-hot when lit, registered
frame_start  out  1  one-cycle pulse when digit 0's slot begins

Behaviour:
- Reset values: prescaler = 0, digit index = 0, pending and active buffers = 0, segments = all inactive (all 1 when SEG_ACTIVE_LOW, else all 0), digit_drive = all inactive, frame_start = 0. Reset mid-frame aborts the scan immediately and discards pending data.
- Prescaler increments every clock and wraps at 2**PRESCALE_W-1. Each wrap advances the digit index 0,1,..,DIGITS-1,0. Digit index DIGITS-1 wraps to 0 for any DIGITS, including values that are not powers of two.
- Frame boundary: the digit index goes DIGITS-1 -> 0. In that same cycle, pending is copied to active if a load has occurred since the last copy, and frame_start is registered high for one cycle.
- load captures the inputs into pending in the same cycle. If load coincides with a frame boundary, the new values are captured into pending and reach active at the next boundary, not the current one. Multiple loads in one frame: the last one wins.
- Segment decode: hex 0-F uses the standard a-g patterns: 0 = 1111110, 1 = 0110000, 8 = 1111111, A = 1110111, b = 0011111, F = 1000111. dp = dots[idx].
- Leading-zero suppression: when active lz_suppress = 1, digit i is blanked if nibbles i..DIGITS-1 are all zero and i != 0. Digit 0 is never suppressed. A blanked digit drives all segments inactive, but its dp is still shown.
- PWM: the digit is lit while prescaler[PRESCALE_W-1 -: BRIGHT_W] < brightness. Brightness 0 = never lit; max = (2**BRIGHT_W-1)/2**BRIGHT_W duty. brightness is sampled live, not buffered.
- The selected digit is lit only when active digit_enables[idx] = 1 and the PWM is on. When not lit, digit_drive is all inactive and segments are all inactive (ghosting guard).
- Latency: outputs are registered, one clock after the prescaler/index state they reflect.
- Polarity is applied only at the output register. All internal logic is active-high.

Decomposition:
- Package seven_seg_pkg: the 7-bit pattern type, the hex_to_seg function (16-entry table), and the SEG_OFF pattern constant.
- Sub-module seven_seg_scan_timer: prescaler, digit index, frame-boundary and frame_start generation, PWM compare. The top level holds the buffers, decode, blanking and output registers.

Test Plan:
All scenarios use PRESCALE_W=4, BRIGHT_W=2, DIGITS=4, SEG_ACTIVE_LOW=0, DIG_ACTIVE_LOW=1, brightness=3 unless noted.
- Basic scan: load number=16'h12AF, enables=4'hF, dots=0 -> after the next frame_start, slot 0 shows 1000111 with digit_drive=1110; slot 3 shows 0110000 with digit_drive=0111; each slot lit 12 of 16 clocks.
- Double buffering: load 16'h1111 mid-frame, then load 16'h2222 in the same frame -> the current frame keeps the old data, and the next frame shows only 2 (1101101).
- Leading zeros: load 16'h0050 with lz_suppress=1 -> digits 3 and 2 blank, digit 1 shows 5, digit 0 shows 0. Load 16'h0000 -> only digit 0 shows 0.
- Brightness and enables: brightness=0 -> digit_drive=1111 and segments=0 permanently. Brightness=1 -> 4 of 16 clocks lit. enables=4'b0101 -> digits 1 and 3 never driven.
- Reset mid-frame, then DIGITS=3: assert reset_n=0 during slot 2 -> outputs go to their reset values asynchronously, frame_start stays 0, and the index restarts at 0 after release. With DIGITS=3, the index cycles 0,1,2,0 and frame_start occurs every 48 clocks.
